button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_if.sv | 21 ++
 rtl/button_conditioner.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/button_conditioner_if.sv
// Button bundle: raw active-low buttons in, debounced levels and one-cycle press pulses out.
interface button_conditioner_if;
    logic [5:0] btn_n;
    logic       feeding1;
    logic       light_out1;
    logic       echo_sig1;
    logic       healing1;
    logic       change_state1;
    logic       test1;
    logic [5:0] stable_n;

    modport master (
        output btn_n,
        input  feeding1, light_out1, echo_sig1, healing1, change_state1, test1, stable_n
    );

    modport slave (
        input  btn_n,
        output feeding1, light_out1, echo_sig1, healing1, change_state1, test1, stable_n
    );
endinterface

// File: rtl/button_conditioner.sv
// Six independent button debouncers with active-low press pulses; button 5 pulses only
// after a long hold instead of on the debounced press.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 250000000
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);
    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1)   ? $clog2(DEBOUNCE_CYCLES)   : 1;
    localparam int LONG_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {REL, PRS_CHK, PRS, REL_CHK} state_t;

    logic [5:0]        r_sync1;
    logic [5:0]        r_sync2;
    logic [5:0]        w_new_press;
    logic [5:0]        w_stable;
    logic [4:0]        w_pulse;
    logic              w_prs5;
    logic              w_rel5;
    logic [LONG_W-1:0] r_long;
    logic              r_armed;
    logic              r_test;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= bus.btn_n;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_btn
            state_t           r_state;
            logic [CNT_W-1:0] r_cnt;
            logic             r_stable;
            logic             w_in;

            assign w_in            = r_sync2[gi];
            assign w_new_press[gi] = (r_state == PRS_CHK) && !w_in && (r_cnt == DEB_LAST);
            assign w_stable[gi]    = r_stable;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_state  <= REL;
                    r_cnt    <= '0;
                    r_stable <= 1'b1;
                end else begin
                    case (r_state)
                        REL: begin
                            if (!w_in) begin
                                r_state <= PRS_CHK;
                                r_cnt   <= '0;
                            end
                        end
                        PRS_CHK: begin
                            if (w_in) begin
                                r_state <= REL;
                            end else if (r_cnt == DEB_LAST) begin
                                r_state  <= PRS;
                                r_stable <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        PRS: begin
                            if (w_in) begin
                                r_state <= REL_CHK;
                                r_cnt   <= '0;
                            end
                        end
                        REL_CHK: begin
                            // A short release falls back to PRS with the level still held low.
                            if (!w_in) begin
                                r_state <= PRS;
                            end else if (r_cnt == DEB_LAST) begin
                                r_state  <= REL;
                                r_stable <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        default: r_state <= REL;
                    endcase
                end
            end

            if (gi < 5) begin : g_pulse
                logic r_pulse;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_pulse <= 1'b1;
                    end else begin
                        r_pulse <= !w_new_press[gi];
                    end
                end
                assign w_pulse[gi] = r_pulse;
            end else begin : g_state5
                assign w_prs5 = (r_state == PRS);
                assign w_rel5 = (r_state == REL);
            end
        end
    endgenerate

    // Long-press timer survives short releases; only a fresh debounced press restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_long  <= '0;
            r_armed <= 1'b1;
            r_test  <= 1'b1;
        end else begin
            r_test <= 1'b1;
            if (w_new_press[5]) begin
                r_long <= '0;
            end else if (w_prs5) begin
                if (r_long == LONG_LAST) begin
                    if (r_armed) begin
                        r_test  <= 1'b0;
                        r_armed <= 1'b0;
                    end
                end else begin
                    r_long <= r_long + 1'b1;
                end
            end
            if (w_rel5) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign bus.feeding1      = w_pulse[0];
    assign bus.light_out1    = w_pulse[1];
    assign bus.echo_sig1     = w_pulse[2];
    assign bus.healing1      = w_pulse[3];
    assign bus.change_state1 = w_pulse[4];
    assign bus.test1         = r_test;
    assign bus.stable_n      = w_stable;
endmodule
